axil_mem_arbiter: RTL and testbench

- Two-requester arbiter that shares one AXI-lite master port between native memory requesters, e.g. instruction fetch (r0) and load/store unit (r1) of the pipelined core.
- Each requester uses the team's simple valid/ready/write/addr/wdata memory interface.
- The block round-robin-arbitrates, registers the winning request, and sequences the full AXI-lite transaction: AW+W then B, or AR then R.
- The completion pulse, read data and error flag are returned to the winner only.

---
 rtl/axil_arb_pkg.sv | 22 ++
 rtl/axil_mem_arbiter_if.sv | 32 +++
 rtl/axil_mem_arbiter_rr_arb2.sv | 20 ++
 rtl/axil_mem_arbiter.sv | 155 +++++++++++++++
 tb/tb_axil_mem_arbiter.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/axil_arb_pkg.sv
// Shared types and constants for the two-requester AXI-lite memory arbiter.
package axil_arb_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_ADDR = 3'd1,
        WR_RESP = 3'd2,
        RD_ADDR = 3'd3,
        RD_DATA = 3'd4,
        DONE    = 3'd5
    } arb_state_e;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp != AXI_RESP_OKAY;
    endfunction

endpackage

// File: rtl/axil_mem_arbiter_if.sv
// AXI-lite bus (no prot/strobe) connecting the arbiter's master port to a slave.
interface axil_mem_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] awaddr;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axil_mem_arbiter_rr_arb2.sv
// Combinational two-way round-robin picker: on a conflict the requester that
// did not win last time is chosen.
module rr_arb2
    import axil_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       gnt_valid,
    output logic       gnt_id
);
    always_comb begin
        gnt_valid = |req;
        gnt_id    = REQ0;
        if (req == 2'b11) begin
            gnt_id = ~last_grant;
        end else if (req[1]) begin
            gnt_id = REQ1;
        end
    end
endmodule

// File: rtl/axil_mem_arbiter.sv
// Shares one AXI-lite master port between two native memory requesters.
// Optional grant/conflict counters are enabled with `define AXIL_ARB_PERF_CNT_EN.
module axil_mem_arbiter
    import axil_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  r0_valid,
    input  logic                  r0_write,
    input  logic [ADDR_WIDTH-1:0] r0_addr,
    input  logic [DATA_WIDTH-1:0] r0_wdata,
    output logic                  r0_ready,
    output logic [DATA_WIDTH-1:0] r0_rdata,
    output logic                  r0_err,
    input  logic                  r1_valid,
    input  logic                  r1_write,
    input  logic [ADDR_WIDTH-1:0] r1_addr,
    input  logic [DATA_WIDTH-1:0] r1_wdata,
    output logic                  r1_ready,
    output logic [DATA_WIDTH-1:0] r1_rdata,
    output logic                  r1_err,
`ifdef AXIL_ARB_PERF_CNT_EN
    output logic [31:0]           perf_grant0,
    output logic [31:0]           perf_grant1,
    output logic [31:0]           perf_conflict,
`endif
    axil_mem_arbiter_if.master    m_axil
);
    arb_state_e state, state_nxt;

    logic                  gnt_valid, gnt_id;
    logic                  last_grant, gnt_id_q;
    logic                  sel_write;
    logic [ADDR_WIDTH-1:0] sel_addr, addr_q;
    logic [DATA_WIDTH-1:0] sel_wdata, wdata_q;
    logic                  aw_done_q, w_done_q, aw_done_d, w_done_d;
    logic                  awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
    logic [DATA_WIDTH-1:0] rsp_data_d;
    logic                  rsp_err_d;

    rr_arb2 u_rr_arb2 (
        .req        ({r1_valid, r0_valid}),
        .last_grant (last_grant),
        .gnt_valid  (gnt_valid),
        .gnt_id     (gnt_id)
    );

    assign sel_write = (gnt_id == REQ1) ? r1_write : r0_write;
    assign sel_addr  = (gnt_id == REQ1) ? r1_addr  : r0_addr;
    assign sel_wdata = (gnt_id == REQ1) ? r1_wdata : r0_wdata;

    // AW and W complete independently; a handshake in this cycle counts as done.
    assign aw_done_d = (state == WR_ADDR) && (aw_done_q || (awvalid_q && m_axil.awready));
    assign w_done_d  = (state == WR_ADDR) && (w_done_q  || (wvalid_q  && m_axil.wready));

    assign rsp_data_d = (state == RD_DATA) ? m_axil.rdata : '0;
    assign rsp_err_d  = (state == RD_DATA) ? resp_is_err(m_axil.rresp)
                                           : resp_is_err(m_axil.bresp);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (gnt_valid) state_nxt = sel_write ? WR_ADDR : RD_ADDR;
            WR_ADDR: if (aw_done_d && w_done_d) state_nxt = WR_RESP;
            WR_RESP: if (m_axil.bvalid) state_nxt = DONE;
            RD_ADDR: if (m_axil.arready) state_nxt = RD_DATA;
            RD_DATA: if (m_axil.rvalid) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Every outward signal is a flop loaded from the next state, so it is
    // glitch-free and holds steady while its channel is stalled.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_grant <= REQ1;
            gnt_id_q   <= REQ0;
            addr_q     <= '0;
            wdata_q    <= '0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            bready_q   <= 1'b0;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
            r0_ready   <= 1'b0;
            r0_rdata   <= '0;
            r0_err     <= 1'b0;
            r1_ready   <= 1'b0;
            r1_rdata   <= '0;
            r1_err     <= 1'b0;
        end else begin
            if (state == IDLE && gnt_valid) begin
                addr_q     <= sel_addr;
                wdata_q    <= sel_wdata;
                last_grant <= gnt_id;
                gnt_id_q   <= gnt_id;
            end
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            awvalid_q <= (state_nxt == WR_ADDR) && !aw_done_d;
            wvalid_q  <= (state_nxt == WR_ADDR) && !w_done_d;
            bready_q  <= (state_nxt == WR_RESP);
            arvalid_q <= (state_nxt == RD_ADDR);
            rready_q  <= (state_nxt == RD_DATA);
            r0_ready  <= (state_nxt == DONE) && (gnt_id_q == REQ0);
            r1_ready  <= (state_nxt == DONE) && (gnt_id_q == REQ1);
            r0_rdata  <= ((state_nxt == DONE) && (gnt_id_q == REQ0)) ? rsp_data_d : '0;
            r1_rdata  <= ((state_nxt == DONE) && (gnt_id_q == REQ1)) ? rsp_data_d : '0;
            r0_err    <= (state_nxt == DONE) && (gnt_id_q == REQ0) && rsp_err_d;
            r1_err    <= (state_nxt == DONE) && (gnt_id_q == REQ1) && rsp_err_d;
        end
    end

    assign m_axil.awaddr  = addr_q;
    assign m_axil.awvalid = awvalid_q;
    assign m_axil.wdata   = wdata_q;
    assign m_axil.wvalid  = wvalid_q;
    assign m_axil.bready  = bready_q;
    assign m_axil.araddr  = addr_q;
    assign m_axil.arvalid = arvalid_q;
    assign m_axil.rready  = rready_q;

`ifdef AXIL_ARB_PERF_CNT_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            perf_grant0   <= '0;
            perf_grant1   <= '0;
            perf_conflict <= '0;
        end else begin
            if (state == IDLE && gnt_valid) begin
                if (gnt_id == REQ0) perf_grant0 <= perf_grant0 + 32'd1;
                else                perf_grant1 <= perf_grant1 + 32'd1;
            end
            if (state == IDLE && r0_valid && r1_valid) begin
                perf_conflict <= perf_conflict + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_axil_mem_arbiter.sv
// Directed bench for axil_mem_arbiter: the AXI-lite slave is driven step by step.
module tb_axil_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rstn;
    logic          r0_valid, r0_write, r0_ready, r0_err;
    logic [AW-1:0] r0_addr;
    logic [DW-1:0] r0_wdata, r0_rdata;
    logic          r1_valid, r1_write, r1_ready, r1_err;
    logic [AW-1:0] r1_addr;
    logic [DW-1:0] r1_wdata, r1_rdata;
`ifdef AXIL_ARB_PERF_CNT_EN
    logic [31:0]   perf_grant0, perf_grant1, perf_conflict;
`endif

    int checks = 0;
    int errors = 0;

    axil_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m_axil ();

    axil_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .r0_valid      (r0_valid),
        .r0_write      (r0_write),
        .r0_addr       (r0_addr),
        .r0_wdata      (r0_wdata),
        .r0_ready      (r0_ready),
        .r0_rdata      (r0_rdata),
        .r0_err        (r0_err),
        .r1_valid      (r1_valid),
        .r1_write      (r1_write),
        .r1_addr       (r1_addr),
        .r1_wdata      (r1_wdata),
        .r1_ready      (r1_ready),
        .r1_rdata      (r1_rdata),
        .r1_err        (r1_err),
`ifdef AXIL_ARB_PERF_CNT_EN
        .perf_grant0   (perf_grant0),
        .perf_grant1   (perf_grant1),
        .perf_conflict (perf_conflict),
`endif
        .m_axil        (m_axil)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Zero-wait read: entered in the IDLE cycle with the request presented, leaves in DONE.
    task automatic read_round(input logic id, input logic [31:0] addr, input logic [31:0] data,
                              input logic [1:0] resp, input logic exp_err);
        step();
        chk("rd_arvalid", m_axil.arvalid, 1);
        chk("rd_araddr", m_axil.araddr, addr);
        chk("rd_awvalid", m_axil.awvalid, 0);
        m_axil.arready = 1'b1;
        step();
        m_axil.arready = 1'b0;
        chk("rd_arvalid_drop", m_axil.arvalid, 0);
        chk("rd_rready", m_axil.rready, 1);
        m_axil.rvalid = 1'b1;
        m_axil.rdata  = data;
        m_axil.rresp  = resp;
        step();
        m_axil.rvalid = 1'b0;
        m_axil.rdata  = '0;
        m_axil.rresp  = 2'b00;
        chk("rd_ready0", r0_ready, id == 1'b0);
        chk("rd_ready1", r1_ready, id == 1'b1);
        chk("rd_rdata", id ? r1_rdata : r0_rdata, data);
        chk("rd_err", id ? r1_err : r0_err, exp_err);
    endtask

    // Zero-wait write with AW and W accepted in the same cycle.
    task automatic write_round(input logic id, input logic [31:0] addr, input logic [31:0] data);
        step();
        chk("wr_awvalid", m_axil.awvalid, 1);
        chk("wr_wvalid", m_axil.wvalid, 1);
        chk("wr_awaddr", m_axil.awaddr, addr);
        chk("wr_wdata", m_axil.wdata, data);
        m_axil.awready = 1'b1;
        m_axil.wready  = 1'b1;
        step();
        m_axil.awready = 1'b0;
        m_axil.wready  = 1'b0;
        chk("wr_aw_w_drop", {m_axil.awvalid, m_axil.wvalid}, 0);
        chk("wr_bready", m_axil.bready, 1);
        m_axil.bvalid = 1'b1;
        m_axil.bresp  = 2'b00;
        step();
        m_axil.bvalid = 1'b0;
        chk("wr_ready0", r0_ready, id == 1'b0);
        chk("wr_ready1", r1_ready, id == 1'b1);
        chk("wr_rdata", id ? r1_rdata : r0_rdata, 0);
        chk("wr_err", id ? r1_err : r0_err, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstn = 1'b0;
        r0_valid = 0; r0_write = 0; r0_addr = '0; r0_wdata = '0;
        r1_valid = 0; r1_write = 0; r1_addr = '0; r1_wdata = '0;
        m_axil.awready = 0; m_axil.wready = 0; m_axil.bvalid = 0; m_axil.bresp = 2'b00;
        m_axil.arready = 0; m_axil.rvalid = 0; m_axil.rdata = '0; m_axil.rresp = 2'b00;
        repeat (2) step();

        chk("rst_valids", {m_axil.awvalid, m_axil.wvalid, m_axil.arvalid}, 0);
        chk("rst_readies", {m_axil.bready, m_axil.rready, r0_ready, r1_ready}, 0);
        chk("rst_errs", {r0_err, r1_err}, 0);
        chk("rst_awaddr", m_axil.awaddr, 0);
        chk("rst_wdata", m_axil.wdata, 0);
        chk("rst_rdata", r0_rdata | r1_rdata, 0);
        rstn = 1'b1;
        step();

        // Single read from r0
        r0_valid = 1; r0_write = 0; r0_addr = 32'h100;
        read_round(1'b0, 32'h100, 32'hDEADBEEF, 2'b00, 1'b0);
        r0_valid = 0;
        step();
        chk("single_ready_pulse", r0_ready, 0);

        // Split write from r1: AW accepted in cycle 1, W in cycle 3
        r1_valid = 1; r1_write = 1; r1_addr = 32'h200; r1_wdata = 32'h12345678;
        step();
        chk("split_c1_valids", {m_axil.awvalid, m_axil.wvalid}, 2'b11);
        chk("split_awaddr", m_axil.awaddr, 32'h200);
        chk("split_wdata", m_axil.wdata, 32'h12345678);
        m_axil.awready = 1;
        step();
        m_axil.awready = 0;
        chk("split_c2_valids", {m_axil.awvalid, m_axil.wvalid}, 2'b01);
        chk("split_c2_bready", m_axil.bready, 0);
        step();
        chk("split_c3_valids", {m_axil.awvalid, m_axil.wvalid}, 2'b01);
        chk("split_c3_wdata", m_axil.wdata, 32'h12345678);
        m_axil.wready = 1;
        step();
        m_axil.wready = 0;
        chk("split_c4_valids", {m_axil.awvalid, m_axil.wvalid}, 2'b00);
        chk("split_c4_bready", m_axil.bready, 1);
        m_axil.bvalid = 1; m_axil.bresp = 2'b00;
        step();
        m_axil.bvalid = 0;
        chk("split_r1_ready", r1_ready, 1);
        chk("split_r0_ready", r0_ready, 0);
        chk("split_r1_err", r1_err, 0);
        chk("split_r1_rdata", r1_rdata, 0);
        r1_valid = 0;
        step();
        chk("split_ready_pulse", {r1_ready, m_axil.bready}, 0);

        // Unsolicited responses in IDLE are ignored
        m_axil.bvalid = 1; m_axil.rvalid = 1;
        step();
        m_axil.bvalid = 0; m_axil.rvalid = 0;
        chk("unsolicited", {r0_ready, r1_ready, m_axil.bready, m_axil.rready}, 0);

        // Conflicts: both held valid, grants alternate 0,1,0,1
        r0_valid = 1; r0_write = 0; r0_addr = 32'h300;
        r1_valid = 1; r1_write = 1; r1_addr = 32'h400; r1_wdata = 32'hCAFE0001;
        read_round(1'b0, 32'h300, 32'h11110000, 2'b00, 1'b0);
        step();
        write_round(1'b1, 32'h400, 32'hCAFE0001);
        step();
        read_round(1'b0, 32'h300, 32'h22220000, 2'b00, 1'b0);
        step();
        write_round(1'b1, 32'h400, 32'hCAFE0001);
        r0_valid = 0; r1_valid = 0;
        step();
`ifdef AXIL_ARB_PERF_CNT_EN
        chk("perf_grant0", perf_grant0, 3);
        chk("perf_grant1", perf_grant1, 3);
        chk("perf_conflict", perf_conflict, 4);
`endif

        // Error response followed by an OKAY one
        r0_valid = 1; r0_write = 0; r0_addr = 32'h800;
        read_round(1'b0, 32'h800, 32'hBAD0BAD0, 2'b10, 1'b1);
        r0_addr = 32'h804;
        step();
        read_round(1'b0, 32'h804, 32'h00005A5A, 2'b00, 1'b0);
        r0_valid = 0;
        step();

        // Reset while waiting for B on an r0 write
        r0_valid = 1; r0_write = 1; r0_addr = 32'h500; r0_wdata = 32'hA5A5A5A5;
        step();
        m_axil.awready = 1; m_axil.wready = 1;
        step();
        m_axil.awready = 0; m_axil.wready = 0;
        chk("mid_bready_before", m_axil.bready, 1);
        #2 rstn = 1'b0;
        #1;
        chk("mid_rst_valids", {m_axil.awvalid, m_axil.wvalid, m_axil.arvalid}, 0);
        chk("mid_rst_readies", {m_axil.bready, m_axil.rready, r0_ready, r1_ready}, 0);
        chk("mid_rst_data", m_axil.awaddr | m_axil.wdata, 0);
        r0_valid = 0;
        step();
        step();
        rstn = 1'b1;
        step();
        r0_valid = 1; r0_write = 0; r0_addr = 32'h700;
        r1_valid = 1; r1_write = 0; r1_addr = 32'h600;
        read_round(1'b0, 32'h700, 32'h77777777, 2'b00, 1'b0);
        r0_valid = 0;
        step();
        read_round(1'b1, 32'h600, 32'h66666666, 2'b00, 1'b0);
        r1_valid = 0;
        step();
        chk("final_idle", {r0_ready, r1_ready, m_axil.arvalid, m_axil.awvalid}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
